// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the dmem_lsu load/store sequencer: access sizes,
// byte-lane offsets, FSM states and the alignment check.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Big-endian: offset 0 is the most significant byte of the word.
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Byte-lane datapath for dmem_lsu: extracts and extends load data, and merges
// byte/half store data into a read-back word (big-endian lane order).
module dmem_lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: select the addressed lane and sign/zero-extend it.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_load = 32'h0000_0000;
    case (i_off)
      OFF_B0:  w_byte = i_word[31:24];
      OFF_B1:  w_byte = i_word[23:16];
      OFF_B2:  w_byte = i_word[15:8];
      OFF_B3:  w_byte = i_word[7:0];
      default: w_byte = 8'h00;
    endcase
    if (i_off[1]) begin
      w_half = i_word[15:0];
    end else begin
      w_half = i_word[31:16];
    end
    case (i_size)
      SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
      SZ_WORD: o_load = i_word;
      default: o_load = 32'h0000_0000;
    endcase
  end

  // Store path: overwrite only the addressed lane of the read-back word.
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        case (i_off)
          OFF_B0:  o_merged[31:24] = i_wdata[7:0];
          OFF_B1:  o_merged[23:16] = i_wdata[7:0];
          OFF_B2:  o_merged[15:8]  = i_wdata[7:0];
          OFF_B3:  o_merged[7:0]   = i_wdata[7:0];
          default: o_merged = i_word;
        endcase
      end
      SZ_HALF: begin
        if (i_off[1]) begin
          o_merged[15:0] = i_wdata[15:0];
        end else begin
          o_merged[31:16] = i_wdata[15:0];
        end
      end
      SZ_WORD: o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer in front of a word-wide big-endian data memory.
// Optional DMEM_LSU_STATS_EN adds saturating load/store/error counters.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
`ifdef DMEM_LSU_STATS_EN
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_errs,
`endif
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t             r_state;
  logic [1:0]         r_off;
  logic [1:0]         r_size;
  logic               r_signed;
  logic               r_write;
  logic [31:0]        r_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_resp_valid;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_err;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_mem_re;
  logic               r_mem_we;

  logic               w_bad;
  logic [ADDR_W-1:0]  w_word_addr;
  logic [31:0]        w_load;
  logic [31:0]        w_merged;

  assign w_bad       = lsu_bad_access(req_size, req_addr[1:0]);
  assign w_word_addr = {req_addr[ADDR_W-1:2], 2'b00};

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;

  dmem_lsu_lane u_lane (
    .i_word   (mem_rdata),
    .i_off    (r_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // Sequencer FSM; all memory and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_off        <= 2'b00;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= 32'h0000_0000;
      r_cnt        <= CNT_ZERO;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= 32'h0000_0000;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_mem_re     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= {ADDR_W{1'b0}};
          r_mem_wdata  <= 32'h0000_0000;
          if (req_valid) begin
            r_off    <= req_addr[1:0];
            r_size   <= req_size;
            r_signed <= req_signed;
            r_write  <= req_write;
            r_wdata  <= req_wdata;
            r_cnt    <= CNT_ZERO;
            if (w_bad) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0000_0000;
            end else if (req_write && (req_size == SZ_WORD)) begin
              r_state     <= ST_WRITE;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_word_addr;
              r_mem_wdata <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a read.
              r_state    <= ST_READ;
              r_mem_re   <= 1'b1;
              r_mem_addr <= w_word_addr;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (r_cnt == CNT_LAST) begin
            r_mem_re <= 1'b0;
            if (r_write) begin
              r_state     <= ST_WRITE;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_merged;
            end else begin
              r_state      <= ST_RESP;
              r_mem_addr   <= {ADDR_W{1'b0}};
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= w_load;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_WRITE: begin
          r_state      <= ST_RESP;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= {ADDR_W{1'b0}};
          r_mem_wdata  <= 32'h0000_0000;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0000_0000;
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_mem_re     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

`ifdef DMEM_LSU_STATS_EN
  logic [15:0] r_stat_loads;
  logic [15:0] r_stat_stores;
  logic [15:0] r_stat_errs;

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errs   = r_stat_errs;

  // Saturating per-class completion counters, bumped on the RESP cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_loads  <= 16'h0000;
      r_stat_stores <= 16'h0000;
      r_stat_errs   <= 16'h0000;
    end else if (r_state == ST_RESP) begin
      if (r_resp_err) begin
        if (r_stat_errs != 16'hFFFF) r_stat_errs <= r_stat_errs + 16'h0001;
        else r_stat_errs <= r_stat_errs;
      end else if (r_write) begin
        if (r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'h0001;
        else r_stat_stores <= r_stat_stores;
      end else begin
        if (r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'h0001;
        else r_stat_loads <= r_stat_loads;
      end
    end else begin
      r_stat_loads  <= r_stat_loads;
      r_stat_stores <= r_stat_stores;
      r_stat_errs   <= r_stat_errs;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: instance a uses RD_LAT=1, instance b RD_LAT=3,
// each with its own byte-addressed big-endian memory model.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic mem_init;
  int   tests = 0;
  int   fails = 0;

  logic        a_req_valid, a_req_ready, a_req_write, a_req_signed;
  logic [1:0]  a_req_size;
  logic [7:0]  a_req_addr, a_mem_addr;
  logic [31:0] a_req_wdata, a_resp_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_resp_valid, a_resp_err, a_mem_re, a_mem_we;
  logic        b_req_valid, b_req_ready, b_req_write, b_req_signed;
  logic [1:0]  b_req_size;
  logic [7:0]  b_req_addr, b_mem_addr;
  logic [31:0] b_req_wdata, b_resp_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_resp_valid, b_resp_err, b_mem_re, b_mem_we;
`ifdef DMEM_LSU_STATS_EN
  logic [15:0] a_stat_loads, a_stat_stores, a_stat_errs;
  logic [15:0] b_stat_loads, b_stat_stores, b_stat_errs;
`endif

  dmem_lsu #(.ADDR_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_re(a_mem_re), .mem_we(a_mem_we),
`ifdef DMEM_LSU_STATS_EN
    .stat_loads(a_stat_loads), .stat_stores(a_stat_stores), .stat_errs(a_stat_errs),
`endif
    .mem_rdata(a_mem_rdata)
  );

  dmem_lsu #(.ADDR_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_re(b_mem_re), .mem_we(b_mem_we),
`ifdef DMEM_LSU_STATS_EN
    .stat_loads(b_stat_loads), .stat_stores(b_stat_stores), .stat_errs(b_stat_errs),
`endif
    .mem_rdata(b_mem_rdata)
  );

  // Memory models: data only valid on the last cycle of an RD_LAT-long read.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  int a_re_cnt = 0;
  int b_re_cnt = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 8'h00;
        mem_b[i] <= 8'h00;
      end
      mem_a[16] <= 8'h80; mem_a[17] <= 8'h7F; mem_a[18] <= 8'h12; mem_a[19] <= 8'h34;
      mem_b[16] <= 8'h80; mem_b[17] <= 8'h7F; mem_b[18] <= 8'h12; mem_b[19] <= 8'h34;
    end else begin
      if (a_mem_we) begin
        mem_a[a_mem_addr]       <= a_mem_wdata[31:24];
        mem_a[a_mem_addr+8'd1]  <= a_mem_wdata[23:16];
        mem_a[a_mem_addr+8'd2]  <= a_mem_wdata[15:8];
        mem_a[a_mem_addr+8'd3]  <= a_mem_wdata[7:0];
      end
      if (b_mem_we) begin
        mem_b[b_mem_addr]       <= b_mem_wdata[31:24];
        mem_b[b_mem_addr+8'd1]  <= b_mem_wdata[23:16];
        mem_b[b_mem_addr+8'd2]  <= b_mem_wdata[15:8];
        mem_b[b_mem_addr+8'd3]  <= b_mem_wdata[7:0];
      end
    end
    a_re_cnt <= a_mem_re ? a_re_cnt + 1 : 0;
    b_re_cnt <= b_mem_re ? b_re_cnt + 1 : 0;
  end

  always_comb begin
    a_mem_rdata = 32'hDEADBEEF;
    b_mem_rdata = 32'hDEADBEEF;
    if (a_mem_re && a_re_cnt == 0)
      a_mem_rdata = {mem_a[a_mem_addr], mem_a[a_mem_addr+8'd1], mem_a[a_mem_addr+8'd2], mem_a[a_mem_addr+8'd3]};
    if (b_mem_re && b_re_cnt == 2)
      b_mem_rdata = {mem_b[b_mem_addr], mem_b[b_mem_addr+8'd1], mem_b[b_mem_addr+8'd2], mem_b[b_mem_addr+8'd3]};
  end

  // Issue one request on instance a (which=0) or b (which=1) and observe it
  // cycle by cycle; k counts cycles after the accept cycle T.
  task automatic do_req(input int which, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [7:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int re_n, output int we_n, output int re_first, output int we_first,
                        output logic [7:0] maddr, output logic [31:0] mwdata, output logic resp_after);
    int wait_n;
    logic rdy;
    lat = -1; rdata = 32'hBAD0BAD0; err = 1'b0; re_n = 0; we_n = 0;
    re_first = -1; we_first = -1; maddr = 8'h00; mwdata = 32'h0; resp_after = 1'b0;
    @(negedge clk);
    if (which == 0) begin
      a_req_valid = 1'b1; a_req_write = w; a_req_size = sz; a_req_signed = sg;
      a_req_addr = addr; a_req_wdata = wd;
    end else begin
      b_req_valid = 1'b1; b_req_write = w; b_req_size = sz; b_req_signed = sg;
      b_req_addr = addr; b_req_wdata = wd;
    end
    wait_n = 0;
    rdy = (which == 0) ? a_req_ready : b_req_ready;
    while (!rdy && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
      rdy = (which == 0) ? a_req_ready : b_req_ready;
    end
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if ((which == 0) ? a_mem_re : b_mem_re) begin
        re_n++;
        if (re_first < 0) re_first = k;
        maddr = (which == 0) ? a_mem_addr : b_mem_addr;
      end
      if ((which == 0) ? a_mem_we : b_mem_we) begin
        we_n++;
        if (we_first < 0) we_first = k;
        maddr  = (which == 0) ? a_mem_addr : b_mem_addr;
        mwdata = (which == 0) ? a_mem_wdata : b_mem_wdata;
      end
      if ((which == 0) ? a_resp_valid : b_resp_valid) begin
        lat   = k;
        rdata = (which == 0) ? a_resp_rdata : b_resp_rdata;
        err   = (which == 0) ? a_resp_err : b_resp_err;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      resp_after = (which == 0) ? a_resp_valid : b_resp_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_init = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_size = SZ_BYTE; a_req_signed = 1'b0;
    a_req_addr = 8'h00; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = SZ_BYTE; b_req_signed = 1'b0;
    b_req_addr = 8'h00; b_req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", a_req_ready); end
    tests++; if ({a_mem_re, a_mem_we, a_resp_valid, a_resp_err} !== 4'b0000) begin fails++;
      $display("FAIL reset_ctrl got %b exp 0000", {a_mem_re, a_mem_we, a_resp_valid, a_resp_err}); end
    tests++; if ({a_mem_addr, a_mem_wdata, a_resp_rdata} !== 72'h0) begin fails++;
      $display("FAIL reset_data got %h exp 0", {a_mem_addr, a_mem_wdata, a_resp_rdata}); end
    rst_n = 1'b1; mem_init = 1'b0;
    @(negedge clk);
    tests++; if ({a_req_ready, b_req_ready} !== 2'b11) begin fails++;
      $display("FAIL reset_release_ready got %b exp 11", {a_req_ready, b_req_ready}); end
  endtask

  task automatic test_word_load();
    int lat, re_n, we_n, rf, wf; logic [31:0] rd, mw; logic er, ra; logic [7:0] ma;
    do_req(0, 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (lat !== 2) begin fails++; $display("FAIL wload_lat got %0d exp 2", lat); end
    tests++; if (rd !== 32'h807F1234) begin fails++; $display("FAIL wload_data got %h exp 807f1234", rd); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL wload_err got %b exp 0", er); end
    tests++; if (re_n !== 1 || we_n !== 0) begin fails++; $display("FAIL wload_re_we got re=%0d we=%0d exp 1/0", re_n, we_n); end
    tests++; if (ma !== 8'h10) begin fails++; $display("FAIL wload_addr got %h exp 10", ma); end
    tests++; if (ra !== 1'b0) begin fails++; $display("FAIL wload_single_pulse got %b exp 0", ra); end
  endtask

  task automatic test_subword_load();
    int lat, re_n, we_n, rf, wf; logic [31:0] rd, mw; logic er, ra; logic [7:0] ma;
    logic [7:0]  v_addr [7] = '{8'h10, 8'h10, 8'h12, 8'h11, 8'h10, 8'h10, 8'h13};
    logic [1:0]  v_size [7] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE};
    logic        v_sgn  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] v_exp  [7] = '{32'hFFFFFF80, 32'h00000080, 32'h00001234, 32'h0000007F,
                                32'hFFFF807F, 32'h0000807F, 32'h00000034};
    for (int i = 0; i < 7; i++) begin
      do_req(0, 1'b0, v_size[i], v_sgn[i], v_addr[i], 32'h0, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
      tests++; if (rd !== v_exp[i] || lat !== 2) begin fails++;
        $display("FAIL subload_%0d got %h lat %0d exp %h lat 2", i, rd, lat, v_exp[i]); end
    end
  endtask

  task automatic test_errors();
    int lat, re_n, we_n, rf, wf; logic [31:0] rd, mw; logic er, ra; logic [7:0] ma;
    logic       v_w    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] v_size [4] = '{SZ_HALF, SZ_ILL, SZ_WORD, SZ_WORD};
    logic [7:0] v_addr [4] = '{8'h11, 8'h10, 8'h12, 8'h11};
    for (int i = 0; i < 4; i++) begin
      do_req(0, v_w[i], v_size[i], 1'b0, v_addr[i], 32'hFFFFFFFF, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
      tests++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin fails++;
        $display("FAIL err_%0d got lat %0d err %b data %h exp 1/1/0", i, lat, er, rd); end
      tests++; if (re_n !== 0 || we_n !== 0) begin fails++;
        $display("FAIL err_nomem_%0d got re=%0d we=%0d exp 0/0", i, re_n, we_n); end
    end
  endtask

  task automatic test_stores();
    int lat, re_n, we_n, rf, wf; logic [31:0] rd, mw; logic er, ra; logic [7:0] ma;
    do_req(0, 1'b1, SZ_BYTE, 1'b0, 8'h11, 32'h123456AB, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (rf !== 1 || wf !== 2 || re_n !== 1 || we_n !== 1) begin fails++;
      $display("FAIL bstore_seq got re@%0d we@%0d n=%0d/%0d exp 1,2,1/1", rf, wf, re_n, we_n); end
    tests++; if (ma !== 8'h10 || mw !== 32'h80AB1234) begin fails++;
      $display("FAIL bstore_wr got %h:%h exp 10:80ab1234", ma, mw); end
    tests++; if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin fails++;
      $display("FAIL bstore_resp got lat %0d data %h err %b exp 3/0/0", lat, rd, er); end
    do_req(0, 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (rd !== 32'h80AB1234) begin fails++; $display("FAIL bstore_readback got %h exp 80ab1234", rd); end
    do_req(0, 1'b1, SZ_HALF, 1'b0, 8'h12, 32'hCAFEBEEF, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (mw !== 32'h80ABBEEF || lat !== 3) begin fails++;
      $display("FAIL hstore got %h lat %0d exp 80abbeef lat 3", mw, lat); end
    do_req(0, 1'b1, SZ_WORD, 1'b0, 8'h14, 32'h11223344, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (lat !== 2 || re_n !== 0 || wf !== 1 || ma !== 8'h14 || mw !== 32'h11223344) begin fails++;
      $display("FAIL wstore got lat %0d re %0d we@%0d %h:%h exp 2,0,1,14:11223344", lat, re_n, wf, ma, mw); end
    do_req(0, 1'b0, SZ_HALF, 1'b1, 8'h16, 32'h0, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (rd !== 32'h00003344) begin fails++; $display("FAIL wstore_readback got %h exp 00003344", rd); end
  endtask

  task automatic test_reset_mid();
    int lat, re_n, we_n, rf, wf, bad_we, bad_rv; logic [31:0] rd, mw; logic er, ra; logic [7:0] ma;
    bad_we = 0; bad_rv = 0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_size = SZ_BYTE; a_req_signed = 1'b0;
    a_req_addr = 8'h12; a_req_wdata = 32'h00000055;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    @(negedge clk);
    tests++; if (a_mem_re !== 1'b1) begin fails++; $display("FAIL rstmid_in_read got %b exp 1", a_mem_re); end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (a_mem_we) bad_we++;
      if (a_resp_valid) bad_rv++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b exp 1", a_req_ready); end
    repeat (4) begin
      @(negedge clk);
      if (a_mem_we) bad_we++;
      if (a_resp_valid) bad_rv++;
    end
    tests++; if (bad_we !== 0 || bad_rv !== 0) begin fails++;
      $display("FAIL rstmid_quiet got we=%0d resp=%0d exp 0/0", bad_we, bad_rv); end
    do_req(0, 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (rd !== 32'h80ABBEEF) begin fails++; $display("FAIL rstmid_mem got %h exp 80abbeef", rd); end
  endtask

  task automatic test_back_to_back();
    int acc [4]; int rsp [4]; logic [31:0] rdv [4];
    int n_acc, n_rsp, consec;
    n_acc = 0; n_rsp = 0; consec = 0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_size = SZ_WORD; a_req_signed = 1'b0;
    a_req_addr = 8'h10; a_req_wdata = 32'h0;
    for (int t = 0; t < 10; t++) begin
      if (a_req_ready && a_req_valid && n_acc < 4) begin acc[n_acc] = t; n_acc++; end
      if (a_resp_valid && n_rsp < 4) begin
        if (n_rsp > 0 && rsp[n_rsp-1] == t - 1) consec++;
        rsp[n_rsp] = t; rdv[n_rsp] = a_resp_rdata; n_rsp++;
      end
      if (n_acc == 2 && a_req_valid) begin
        @(posedge clk);
        #1 a_req_valid = 1'b0;
      end
      @(negedge clk);
    end
    tests++; if (n_acc !== 2 || acc[0] !== 0 || acc[1] !== 3) begin fails++;
      $display("FAIL b2b_accept got n=%0d at %0d,%0d exp 2 at 0,3", n_acc, acc[0], acc[1]); end
    tests++; if (n_rsp !== 2 || rsp[0] !== 2 || rsp[1] !== 5 || consec !== 0) begin fails++;
      $display("FAIL b2b_resp got n=%0d at %0d,%0d consec %0d exp 2 at 2,5", n_rsp, rsp[0], rsp[1], consec); end
    tests++; if (rdv[0] !== 32'h80ABBEEF || rdv[1] !== 32'h80ABBEEF) begin fails++;
      $display("FAIL b2b_data got %h,%h exp 80abbeef", rdv[0], rdv[1]); end
  endtask

  task automatic test_rdlat3();
    int lat, re_n, we_n, rf, wf; logic [31:0] rd, mw; logic er, ra; logic [7:0] ma;
    do_req(1, 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (lat !== 4 || re_n !== 3 || rd !== 32'h807F1234) begin fails++;
      $display("FAIL lat3_load got lat %0d re %0d data %h exp 4,3,807f1234", lat, re_n, rd); end
    do_req(1, 1'b1, SZ_BYTE, 1'b0, 8'h13, 32'h000000CD, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (lat !== 5 || wf !== 4 || mw !== 32'h807F12CD) begin fails++;
      $display("FAIL lat3_store got lat %0d we@%0d data %h exp 5,4,807f12cd", lat, wf, mw); end
    do_req(1, 1'b0, SZ_BYTE, 1'b1, 8'h10, 32'h0, lat, rd, er, re_n, we_n, rf, wf, ma, mw, ra);
    tests++; if (lat !== 4 || rd !== 32'hFFFFFF80) begin fails++;
      $display("FAIL lat3_sbyte got lat %0d data %h exp 4,ffffff80", lat, rd); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_errors();
    test_stores();
    test_reset_mid();
    test_back_to_back();
    test_rdlat3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
